// File: rtl/sim_exit_device.sv
`default_nettype none
// ============================================================================
//  Module   : sim_exit_device
//  Purpose  : Memory-mapped simulation termination device. A core writes an
//             exit code to end the run, streams console bytes, reads a
//             free-running cycle counter and a status word. A watchdog halts
//             the run with a timeout status when the cycle counter reaches
//             WATCHDOG_CYCLES.
//
//  Register window (32 bytes at BASE_ADDR, word offset = req_addr[4:2]):
//    0 EXIT      W  full-word write halts the device with exit_code = wdata
//    1 CONSOLE   W  write with be[0] emits wdata[7:0] on the putc strobe
//    2 CYCLE_LO  R  cycle_count[31:0]
//    3 CYCLE_HI  R  cycle_count[63:32]
//    4 STATUS    R  {29'b0, err, timeout, halted}
//    5..7        -  error access
//
//  Ports:
//    clk, rst_n                 clock, synchronous active-low reset
//    req_valid/req_ready        request handshake (ready only while running)
//    req_we/req_addr/req_wdata/req_be   request payload
//    resp_valid/resp_rdata      one-cycle response pulse for every accept
//    halted/timeout/exit_code   termination status
//    putc_valid/putc_data       console byte strobe
//    cycle_count                64-bit run counter, frozen once halted
//    err                        sticky bad-access flag
//
//  Revision : 1.0 - initial release
// ============================================================================
module sim_exit_device #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter int unsigned WATCHDOG_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,

    output logic        halted,
    output logic        timeout,
    output logic [31:0] exit_code,

    output logic        putc_valid,
    output logic [7:0]  putc_data,

    output logic [63:0] cycle_count,
    output logic        err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [2:0]  OFF_EXIT     = 3'd0;
    localparam logic [2:0]  OFF_CONSOLE  = 3'd1;
    localparam logic [2:0]  OFF_CYCLE_LO = 3'd2;
    localparam logic [2:0]  OFF_CYCLE_HI = 3'd3;
    localparam logic [2:0]  OFF_STATUS   = 3'd4;

    localparam logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF;
    localparam logic [31:0] TIMEOUT_CODE  = 32'hFFFF_FFFF;
    // Counter value seen in the last running cycle before the watchdog fires.
    localparam logic [63:0] WD_LAST       = 64'(WATCHDOG_CYCLES) - 64'd1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        in_window;
    logic [2:0]  offset;
    logic        is_err;
    logic        exit_wr;
    logic        putc_wr;
    logic        wd_expire;
    logic [31:0] rdata_next;

    logic        halted_next;
    logic        timeout_next;
    logic [31:0] exit_code_next;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic        unused_addr_lo;
    assign unused_addr_lo = ^req_addr[1:0];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    // Ready depends on state only, so the handshake never loops through
    // the decode logic.
    assign req_ready = (state == RUN);
    assign accept    = req_valid && req_ready;

    assign in_window = (req_addr[31:5] == BASE_ADDR[31:5]);
    assign offset    = req_addr[4:2];

    // Classify the access independently of whether it is accepted; the
    // qualifying with 'accept' happens where side effects are applied.
    always_comb begin
        is_err = 1'b0;
        if (!in_window) begin
            is_err = 1'b1;
        end else begin
            case (offset)
                OFF_EXIT:     is_err = req_we && (req_be != 4'b1111);
                OFF_CONSOLE:  is_err = 1'b0;
                OFF_CYCLE_LO,
                OFF_CYCLE_HI,
                OFF_STATUS:   is_err = req_we;
                default:      is_err = 1'b1;
            endcase
        end
    end

    assign exit_wr = accept && in_window && req_we
                     && (offset == OFF_EXIT) && (req_be == 4'b1111);

    // A console write without byte lane 0 is legal but produces no byte.
    assign putc_wr = accept && in_window && req_we
                     && (offset == OFF_CONSOLE) && req_be[0];

    assign wd_expire = (cycle_count == WD_LAST);

    // Read data for the response issued on the next edge. Counter and
    // status values are those present in the accept cycle.
    always_comb begin
        rdata_next = 32'd0;
        if (!req_we) begin
            if (is_err) begin
                rdata_next = ERR_RDATA;
            end else begin
                case (offset)
                    OFF_CYCLE_LO: rdata_next = cycle_count[31:0];
                    OFF_CYCLE_HI: rdata_next = cycle_count[63:32];
                    OFF_STATUS:   rdata_next = {29'd0, err, timeout, halted};
                    default:      rdata_next = 32'd0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Run / halt state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        halted_next    = halted;
        timeout_next   = timeout;
        exit_code_next = exit_code;
        case (state)
            RUN: begin
                // An exit written in the watchdog's final cycle takes
                // priority, so the bench sees its own code, not a timeout.
                if (exit_wr) begin
                    state_next     = HALTED;
                    halted_next    = 1'b1;
                    exit_code_next = req_wdata;
                end else if (wd_expire) begin
                    state_next     = HALTED;
                    halted_next    = 1'b1;
                    timeout_next   = 1'b1;
                    exit_code_next = TIMEOUT_CODE;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status, response, console and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted      <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= 32'd0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            putc_valid  <= 1'b0;
            putc_data   <= 8'd0;
            cycle_count <= 64'd0;
            err         <= 1'b0;
        end else begin
            halted    <= halted_next;
            timeout   <= timeout_next;
            exit_code <= exit_code_next;

            // Requests are only accepted one per cycle and the response
            // register is rewritten every cycle, so each pulse lasts
            // exactly one cycle; rdata is forced to zero between pulses.
            resp_valid <= accept;
            resp_rdata <= accept ? rdata_next : 32'd0;

            putc_valid <= putc_wr;
            if (putc_wr) begin
                putc_data <= req_wdata[7:0];
            end

            // The counter still advances on the edge that enters HALTED,
            // then stays frozen.
            if (state == RUN) begin
                cycle_count <= cycle_count + 64'd1;
            end

            if (accept && is_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sim_exit_device.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sim_exit_device
//  Purpose  : Self-checking bench for sim_exit_device. Directed vector table,
//             hand-written multi-cycle sequences (halt, watchdog, reset) and a
//             randomized phase checked every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sim_exit_device;

    localparam logic [31:0] BASE    = 32'hFFFF_0000;
    localparam int          MAIN_WD = 400;
    localparam int          WD_WD   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        halted;
    logic        timeout;
    logic [31:0] exit_code;
    logic        putc_valid;
    logic [7:0]  putc_data;
    logic [63:0] cycle_count;
    logic        err;

    logic        wd_req_ready;
    logic        wd_resp_valid;
    logic [31:0] wd_resp_rdata;
    logic        wd_halted;
    logic        wd_timeout;
    logic [31:0] wd_exit_code;
    logic        wd_putc_valid;
    logic [7:0]  wd_putc_data;
    logic [63:0] wd_cycle_count;
    logic        wd_err;

    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    sim_exit_device #(.BASE_ADDR(BASE), .WATCHDOG_CYCLES(MAIN_WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .halted(halted), .timeout(timeout), .exit_code(exit_code),
        .putc_valid(putc_valid), .putc_data(putc_data),
        .cycle_count(cycle_count), .err(err)
    );

    // Short-watchdog instance sharing the same stimulus.
    sim_exit_device #(.BASE_ADDR(BASE), .WATCHDOG_CYCLES(WD_WD)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(wd_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(wd_resp_valid), .resp_rdata(wd_resp_rdata),
        .halted(wd_halted), .timeout(wd_timeout), .exit_code(wd_exit_code),
        .putc_valid(wd_putc_valid), .putc_data(wd_putc_data),
        .cycle_count(wd_cycle_count), .err(wd_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model of the main instance
    // ------------------------------------------------------------------
    logic        m_halted, m_timeout, m_err, m_resp_v, m_putc_v;
    logic [31:0] m_exit, m_rdata;
    logic [7:0]  m_putc_d;
    logic [63:0] m_count;

    task automatic model_edge();
        logic        acc;
        logic        bad_acc;
        logic        do_exit;
        logic [31:0] rd;
        int          off;
        if (!rst_n) begin
            m_halted = 0; m_timeout = 0; m_err = 0; m_resp_v = 0; m_putc_v = 0;
            m_exit = 0; m_rdata = 0; m_putc_d = 0; m_count = 0;
            return;
        end
        acc     = req_valid && !m_halted;
        bad_acc = 0;
        do_exit = 0;
        rd      = 0;
        m_putc_v = 0;
        if (acc) begin
            off = int'(req_addr[4:2]);
            if ((req_addr >> 5) != (BASE >> 5)) bad_acc = 1;
            else if (off > 4) bad_acc = 1;
            else if (req_we && off >= 2) bad_acc = 1;
            else if (req_we && off == 0 && req_be != 4'hF) bad_acc = 1;

            if (bad_acc) rd = req_we ? 32'h0 : 32'hDEAD_BEEF;
            else if (!req_we) begin
                if (off == 2) rd = m_count[31:0];
                else if (off == 3) rd = m_count[63:32];
                else if (off == 4) rd = 32'(m_err) * 4 + 32'(m_timeout) * 2 + 32'(m_halted);
            end else if (off == 0) do_exit = 1;
            else if (req_be[0]) begin
                m_putc_v = 1;
                m_putc_d = req_wdata[7:0];
            end
        end
        m_resp_v = acc;
        m_rdata  = rd;
        if (!m_halted) begin
            if (do_exit) begin
                m_halted = 1; m_exit = req_wdata;
            end else if (m_count == 64'(MAIN_WD - 1)) begin
                m_halted = 1; m_timeout = 1; m_exit = 32'hFFFF_FFFF;
            end
            m_count = m_count + 1;
        end
        if (bad_acc) m_err = 1;
    endtask

    always @(posedge clk) begin
        model_edge();
        #1;
        if (mon_en) begin
            chk("m_req_ready", 64'(req_ready), 64'(!m_halted));
            chk("m_resp_valid", 64'(resp_valid), 64'(m_resp_v));
            chk("m_resp_rdata", 64'(resp_rdata), 64'(m_rdata));
            chk("m_halted", 64'(halted), 64'(m_halted));
            chk("m_timeout", 64'(timeout), 64'(m_timeout));
            chk("m_exit_code", 64'(exit_code), 64'(m_exit));
            chk("m_putc_valid", 64'(putc_valid), 64'(m_putc_v));
            if (m_putc_v) chk("m_putc_data", 64'(putc_data), 64'(m_putc_d));
            chk("m_cycle_count", cycle_count, m_count);
            chk("m_err", 64'(err), 64'(m_err));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic idle();
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"},  64'(req_ready), 64'd1);
        chk({tag, "_rv"},     64'(resp_valid), 64'd0);
        chk({tag, "_rdata"},  64'(resp_rdata), 64'd0);
        chk({tag, "_halted"}, 64'(halted), 64'd0);
        chk({tag, "_timeout"},64'(timeout), 64'd0);
        chk({tag, "_exit"},   64'(exit_code), 64'd0);
        chk({tag, "_pv"},     64'(putc_valid), 64'd0);
        chk({tag, "_pd"},     64'(putc_data), 64'd0);
        chk({tag, "_count"},  cycle_count, 64'd0);
        chk({tag, "_err"},    64'(err), 64'd0);
    endtask

    // Leaves rst_n high at a falling edge with cycle_count == 0.
    task automatic do_reset();
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        putc;
        logic [7:0]  pdata;
        logic        err;
    } vec_t;

    function automatic vec_t mk(input string n, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic [31:0] rd, input logic p,
                                input logic [7:0] pd, input logic e);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.wdata = wd; v.be = be;
        v.rdata = rd; v.putc = p; v.pdata = pd; v.err = e;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        logic [26:0] base_hi;
        int          sel;
        base_hi = BASE[31:5];

        vecs[0]  = mk("console",       1, BASE + 32'd4,  32'h48,  4'b0001, 32'h0, 1, 8'h48, 0);
        vecs[1]  = mk("exit_rd",       0, BASE + 32'd0,  32'h0,   4'hF,    32'h0, 0, 8'h0,  0);
        vecs[2]  = mk("console_rd",    0, BASE + 32'd4,  32'h0,   4'hF,    32'h0, 0, 8'h0,  0);
        vecs[3]  = mk("status_clean",  0, BASE + 32'd16, 32'h0,   4'hF,    32'h0, 0, 8'h0,  0);
        vecs[4]  = mk("console_nolane",1, BASE + 32'd4,  32'h1FF, 4'b1110, 32'h0, 0, 8'h0,  0);
        vecs[5]  = mk("out_window_rd", 0, 32'h0000_1000, 32'h0,   4'hF,    32'hDEAD_BEEF, 0, 8'h0, 1);
        vecs[6]  = mk("status_err",    0, BASE + 32'd16, 32'h0,   4'hF,    32'h4, 0, 8'h0,  1);
        vecs[7]  = mk("off5_rd",       0, BASE + 32'd20, 32'h0,   4'hF,    32'hDEAD_BEEF, 0, 8'h0, 1);
        vecs[8]  = mk("off7_rd",       0, BASE + 32'd28, 32'h0,   4'hF,    32'hDEAD_BEEF, 0, 8'h0, 1);
        vecs[9]  = mk("wr_cycle_lo",   1, BASE + 32'd8,  32'd123, 4'hF,    32'h0, 0, 8'h0,  1);
        vecs[10] = mk("exit_partial",  1, BASE + 32'd0,  32'd7,   4'b0011, 32'h0, 0, 8'h0,  1);
        vecs[11] = mk("status_lowbits",0, BASE + 32'd19, 32'h0,   4'hF,    32'h4, 0, 8'h0,  1);
        vecs[12] = mk("wr_out_window", 1, BASE + 32'h24, 32'h0,   4'hF,    32'h0, 0, 8'h0,  1);
        vecs[13] = mk("console_lowbits",1,BASE + 32'd5,  32'h41,  4'b0001, 32'h0, 1, 8'h41, 1);

        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        mon_en = 1;
        check_reset_state("reset");
        rst_n = 1;

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            @(negedge clk);
            idle();
            chk({vecs[i].name, "_rv"},     64'(resp_valid), 64'd1);
            chk({vecs[i].name, "_rdata"},  64'(resp_rdata), 64'(vecs[i].rdata));
            chk({vecs[i].name, "_pv"},     64'(putc_valid), 64'(vecs[i].putc));
            if (vecs[i].putc) chk({vecs[i].name, "_pd"}, 64'(putc_data), 64'(vecs[i].pdata));
            chk({vecs[i].name, "_err"},    64'(err), 64'(vecs[i].err));
            chk({vecs[i].name, "_halted"}, 64'(halted), 64'd0);
            @(negedge clk);
            chk({vecs[i].name, "_rv_pulse"}, 64'(resp_valid), 64'd0);
            chk({vecs[i].name, "_pv_pulse"}, 64'(putc_valid), 64'd0);
            chk({vecs[i].name, "_rdata_idle"}, 64'(resp_rdata), 64'd0);
        end

        // ---------------- cycle counter read at count 37 ----------------
        do_reset();
        repeat (37) @(negedge clk);
        chk("count_37", cycle_count, 64'd37);
        drive(0, BASE + 32'd8, 0, 4'hF);
        @(negedge clk);
        drive(0, BASE + 32'd12, 0, 4'hF);
        chk("cycle_lo_rd", 64'(resp_rdata), 64'd37);
        chk("count_38", cycle_count, 64'd38);
        @(negedge clk);
        idle();
        chk("cycle_hi_rd", 64'(resp_rdata), 64'd0);

        // ---------------- exit write, halt, frozen counter ----------------
        do_reset();
        repeat (5) @(negedge clk);
        drive(1, BASE, 32'h0000_0001, 4'hF);
        @(negedge clk);
        chk("exit_halted", 64'(halted), 64'd1);
        chk("exit_code1", 64'(exit_code), 64'd1);
        chk("exit_ready", 64'(req_ready), 64'd0);
        chk("exit_rv", 64'(resp_valid), 64'd1);
        chk("exit_timeout", 64'(timeout), 64'd0);
        chk("exit_count", cycle_count, 64'd6);
        drive(0, BASE + 32'd16, 0, 4'hF);
        repeat (3) begin
            @(negedge clk);
            chk("halt_no_resp", 64'(resp_valid), 64'd0);
            chk("halt_frozen", cycle_count, 64'd6);
        end

        // ---------------- reset while halted ----------------
        idle();
        rst_n = 0;
        @(negedge clk);
        check_reset_state("rst_halted");
        rst_n = 1;
        drive(1, BASE + 32'd4, 32'h5A, 4'b0001);
        @(negedge clk);
        idle();
        chk("after_rst_pv", 64'(putc_valid), 64'd1);
        chk("after_rst_pd", 64'(putc_data), 64'h5A);
        chk("after_rst_rv", 64'(resp_valid), 64'd1);

        // ---------------- request coinciding with reset ----------------
        drive(1, BASE + 32'd4, 32'h33, 4'b0001);
        rst_n = 0;
        @(negedge clk);
        idle();
        rst_n = 1;
        chk("rst_discard_rv", 64'(resp_valid), 64'd0);
        chk("rst_discard_pv", 64'(putc_valid), 64'd0);

        // ---------------- watchdog (16-cycle instance) ----------------
        do_reset();
        repeat (15) @(negedge clk);
        chk("wd_pre_halted", 64'(wd_halted), 64'd0);
        chk("wd_pre_count", wd_cycle_count, 64'd15);
        @(negedge clk);
        chk("wd_halted", 64'(wd_halted), 64'd1);
        chk("wd_timeout", 64'(wd_timeout), 64'd1);
        chk("wd_exit", 64'(wd_exit_code), 64'hFFFF_FFFF);
        chk("wd_count", wd_cycle_count, 64'd16);
        chk("wd_ready", 64'(wd_req_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("wd_frozen", wd_cycle_count, 64'd16);

        do_reset();
        repeat (15) @(negedge clk);
        drive(1, BASE, 32'd5, 4'hF);
        @(negedge clk);
        idle();
        chk("wd_race_halted", 64'(wd_halted), 64'd1);
        chk("wd_race_timeout", 64'(wd_timeout), 64'd0);
        chk("wd_race_exit", 64'(wd_exit_code), 64'd5);
        chk("wd_race_rv", 64'(wd_resp_valid), 64'd1);

        // ---------------- randomized phase against the model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            sel       = int'($urandom_range(0, 9));
            if (sel < 8) req_addr = {base_hi, 5'($urandom_range(0, 31))};
            else         req_addr = $urandom();
            req_be    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            req_wdata = $urandom();
            // Keep exits rare so long runs (and the watchdog) get exercised.
            if (req_we && req_addr[31:5] == base_hi && req_addr[4:2] == 3'd0
                && $urandom_range(0, 15) != 0) req_we = 0;
            @(negedge clk);
        end
        idle();
        rst_n = 1;
        repeat (3) @(negedge clk);
        mon_en = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sim_exit_device.md
SIM_EXIT_DEVICE -- requirements
Module: sim_exit_device

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, meaning the base of the 32-byte device window.
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 1000000, meaning the cycle count at which the device forces a timeout halt.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have req_valid in 1; req_ready out 1; req_we in 1; req_addr in 32; req_wdata in 32; req_be in 4: the core-side request channel.
REQ-006 SHALL have resp_valid out 1 and resp_rdata out 32: the response channel (no backpressure).
REQ-007 SHALL have halted out 1; timeout out 1; exit_code out 32: termination status for the bench.
REQ-008 SHALL have putc_valid out 1 and putc_data out 8: the console byte strobe.
REQ-009 SHALL have cycle_count out 64 (free-running run counter) and err out 1 (sticky bad-access flag).

Function
REQ-010 SHALL implement states RUN and HALTED; reset enters RUN.
REQ-011 SHALL drive req_ready = 1 in RUN and 0 in HALTED; a request is accepted when req_valid && req_ready.
REQ-012 SHALL decode only when req_addr[31:5] == BASE_ADDR[31:5]; offset = req_addr[4:2]; req_addr[1:0] ignored.
REQ-013 SHALL pulse resp_valid exactly one cycle after every accepted request, read or write; resp_rdata is valid only with resp_valid and is 0 otherwise.
REQ-014 Offset 0 EXIT, write with req_be == 4'b1111: exit_code <= req_wdata, halted <= 1, state -> HALTED on the next edge; reads return 0.
REQ-015 Offset 1 CONSOLE, write with req_be[0] == 1: putc_valid pulses for 1 cycle on the next edge with putc_data = req_wdata[7:0]; reads return 0.
REQ-016 Offsets 2/3 CYCLE_LO/CYCLE_HI: read-only; return cycle_count[31:0]/[63:32] as sampled in the accept cycle.
REQ-017 Offset 4 STATUS: read-only; returns {29'b0, err, timeout, halted}.
REQ-018 Error access SHALL be any of: out-of-window address, offsets 5-7, a write to a read-only offset, or an EXIT write with partial req_be. An error access SHALL be accepted, return 32'hDEAD_BEEF on reads (0 on writes), have no other effect, and set err until reset.
REQ-019 cycle_count SHALL increment by 1 on every edge in RUN, wrap modulo 2^64, and freeze in HALTED.
REQ-020 When cycle_count == WATCHDOG_CYCLES-1 in RUN and no EXIT write is accepted that cycle: next edge sets halted=1, timeout=1, exit_code=32'hFFFF_FFFF, state -> HALTED.
REQ-021 An accepted EXIT write in the watchdog-expiry cycle SHALL win: timeout stays 0 and exit_code = req_wdata.
REQ-022 HALTED SHALL be absorbing until reset; the response for the final accepted request SHALL still be issued.
REQ-023 putc_valid and resp_valid SHALL be single-cycle pulses and never asserted in consecutive cycles for the same request.

Reset
REQ-024 On an edge with rst_n == 0, including mid-response or in HALTED: state=RUN, req_ready=1, resp_valid=0, resp_rdata=0, halted=0, timeout=0, exit_code=0, putc_valid=0, putc_data=0, cycle_count=0, err=0; any pending response or putc SHALL be discarded.

Verification
REQ-025 Write 0x48 to BASE+4 with be=4'b0001 -> next cycle putc_valid=1, putc_data=8'h48, resp_valid=1, rdata=0; halted stays 0.
REQ-026 Write 32'h0000_0001 to BASE+0 with be=4'b1111 -> next cycle halted=1, exit_code=1, req_ready=0; cycle_count frozen thereafter.
REQ-027 Read BASE+8 accepted at cycle_count=37 -> resp_rdata=37 next cycle; read 0x0000_1000 -> rdata=32'hDEAD_BEEF, err=1, STATUS read returns 4.
REQ-028 WATCHDOG_CYCLES=16, idle -> halted=1, timeout=1, exit_code=32'hFFFF_FFFF at cycle_count=16; EXIT write of 5 accepted at count 15 -> timeout=0, exit_code=5.
REQ-029 EXIT write with be=4'b0011 -> halted stays 0, err=1; assert rst_n=0 while halted -> all outputs return to reset values next edge and the device accepts requests.
